// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: MDU op codes, MDU counter
// state and the default multiply/divide busy lengths.
package pipe_ctrl_pkg;

  localparam logic [1:0] MDU_OP_NONE = 2'b00;
  localparam logic [1:0] MDU_OP_MULT = 2'b01;
  localparam logic [1:0] MDU_OP_DIV  = 2'b10;
  localparam logic [1:0] MDU_OP_RSVD = 2'b11;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_busy_cnt.sv
// MDU busy down-counter: loaded when the E-stage launches a mult/div, then
// counts down to zero regardless of pipeline freezes or flushes.
module mdu_busy_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic       i_hold,
  output logic       o_busy
);

  localparam int MAX_CYCLES = max_int(MULT_CYCLES, DIV_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_load_val;
  logic             w_load;
  mdu_state_e       w_state;

  assign w_state = (r_count != '0) ? MDU_BUSY : MDU_IDLE;
  assign o_busy  = (w_state == MDU_BUSY);

  always_comb begin
    w_load_val = '0;
    w_load     = 1'b0;
    case (i_op)
      MDU_OP_MULT: begin
        w_load_val = CNT_W'(MULT_CYCLES);
        w_load     = i_start;
      end
      MDU_OP_DIV: begin
        w_load_val = CNT_W'(DIV_CYCLES);
        w_load     = i_start;
      end
      MDU_OP_NONE, MDU_OP_RSVD: ;
    endcase
  end

  // A start seen while busy is ignored; the count only stops at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      case (w_state)
        MDU_BUSY: r_count <= r_count - CNT_W'(1);
        MDU_IDLE: if (w_load && !i_hold) r_count <= w_load_val;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stage enable/clear controller with MDU structural-hazard stall
// and saturating stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_hazard,
  input  logic        D_mdu_use,
  input  logic        E_mdu_start,
  input  logic [1:0]  E_mdu_op,
  input  logic        M_exc,
  input  logic        bus_wait,
  output logic        F_en,
  output logic        D_en,
  output logic        E_en,
  output logic        M_en,
  output logic        W_en,
  output logic        D_clr,
  output logic        E_clr,
  output logic        M_clr,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  logic        w_mdu_busy;
  logic        w_mdu_launch;
  logic        w_stall;
  logic        w_stall_inc;
  logic        w_flush_inc;
  logic [4:0]  w_en;
  logic [2:0]  w_clr;
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  mdu_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_busy_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_start (E_mdu_start),
    .i_op    (E_mdu_op),
    .i_hold  (M_exc | bus_wait),
    .o_busy  (w_mdu_busy)
  );

  // An op launching in E this cycle already blocks a dependent D instruction.
  assign w_mdu_launch = E_mdu_start && ((E_mdu_op == MDU_OP_MULT) || (E_mdu_op == MDU_OP_DIV));
  assign w_stall      = D_hazard || (D_mdu_use && (w_mdu_busy || w_mdu_launch));

  always_comb begin
    w_en        = 5'b00000;
    w_clr       = 3'b000;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (!reset || bus_wait) begin
      w_en  = 5'b00000;
    end else if (M_exc) begin
      w_en        = 5'b11111;
      w_clr       = 3'b111;
      w_flush_inc = 1'b1;
    end else if (w_stall) begin
      w_en        = 5'b00111;
      w_clr       = 3'b010;
      w_stall_inc = 1'b1;
    end else begin
      w_en  = 5'b11111;
    end
  end

  assign {F_en, D_en, E_en, M_en, W_en} = w_en;
  assign {D_clr, E_clr, M_clr}          = w_clr;
  assign mdu_busy                       = w_mdu_busy;
  assign stall_cycles                   = r_stall_cycles;
  assign flush_count                    = r_flush_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cycles != 32'hFFFF_FFFF)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush_inc && (r_flush_count != 32'hFFFF_FFFF))  r_flush_count  <= r_flush_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic,
// checked every cycle against a cycle-count reference model.
module tb_pipe_ctrl;

  localparam int MULT_LEN = 5;
  localparam int DIV_LEN  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        D_hazard = 1'b0;
  logic        D_mdu_use = 1'b0;
  logic        E_mdu_start = 1'b0;
  logic [1:0]  E_mdu_op = 2'b00;
  logic        M_exc = 1'b0;
  logic        bus_wait = 1'b0;
  logic        F_en, D_en, E_en, M_en, W_en;
  logic        D_clr, E_clr, M_clr;
  logic        mdu_busy;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  typedef struct {
    logic [4:0]  en;
    logic [2:0]  clr;
    logic        busy;
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;
    int          cyc;
  } exp_t;

  exp_t   expQ[$];
  int     checks = 0;
  int     failures = 0;
  int     cycle = 0;
  int     mduLeft = 0;
  longint modelStall = 0;
  longint modelFlush = 0;

  pipe_ctrl #(
    .MULT_CYCLES (MULT_LEN),
    .DIV_CYCLES  (DIV_LEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .D_hazard     (D_hazard),
    .D_mdu_use    (D_mdu_use),
    .E_mdu_start  (E_mdu_start),
    .E_mdu_op     (E_mdu_op),
    .M_exc        (M_exc),
    .bus_wait     (bus_wait),
    .F_en         (F_en),
    .D_en         (D_en),
    .E_en         (E_en),
    .M_en         (M_en),
    .W_en         (W_en),
    .D_clr        (D_clr),
    .E_clr        (E_clr),
    .M_clr        (M_clr),
    .mdu_busy     (mdu_busy),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  // Drives one cycle's inputs just after the edge and queues what the
  // outputs must look like for the rest of that cycle.
  task automatic applyStimulus(input logic rst, input logic hz, input logic use_,
                               input logic st, input logic [1:0] op,
                               input logic exc, input logic bw);
    exp_t e;
    logic isStart;
    logic stall;
    @(posedge clk);
    #1;
    reset = rst; D_hazard = hz; D_mdu_use = use_; E_mdu_start = st;
    E_mdu_op = op; M_exc = exc; bus_wait = bw;
    if (!rst) begin
      mduLeft = 0; modelStall = 0; modelFlush = 0;
    end
    isStart = st && (op == 2'b01 || op == 2'b10);
    stall   = hz || (use_ && (mduLeft > 0 || isStart));
    e.busy  = (mduLeft > 0);
    if (!rst || bw) begin
      e.en = 5'b00000; e.clr = 3'b000;
    end else if (exc) begin
      e.en = 5'b11111; e.clr = 3'b111;
    end else if (stall) begin
      e.en = 5'b00111; e.clr = 3'b010;
    end else begin
      e.en = 5'b11111; e.clr = 3'b000;
    end
    e.stallCnt = modelStall[31:0];
    e.flushCnt = modelFlush[31:0];
    e.cyc      = cycle;
    expQ.push_back(e);
    if (rst) begin
      if (mduLeft > 0) mduLeft--;
      else if (isStart && !exc && !bw) mduLeft = (op == 2'b01) ? MULT_LEN : DIV_LEN;
      if (!bw && !exc && stall && modelStall < 64'hFFFF_FFFF) modelStall++;
      if (!bw && exc && modelFlush < 64'hFFFF_FFFF) modelFlush++;
    end
    cycle++;
  endtask

  task automatic checkField(input string name, input int cyc,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("en{F,D,E,M,W}", e.cyc, 32'({F_en, D_en, E_en, M_en, W_en}), 32'(e.en));
    checkField("clr{D,E,M}", e.cyc, 32'({D_clr, E_clr, M_clr}), 32'(e.clr));
    checkField("mdu_busy", e.cyc, 32'(mdu_busy), 32'(e.busy));
    checkField("stall_cycles", e.cyc, stall_cycles, e.stallCnt);
    checkField("flush_count", e.cyc, flush_count, e.flushCnt);
  endtask

  // Monitor: compares whatever the DUT shows mid-cycle against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int drained;
    // Reset state.
    repeat (2) applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);

    // Mult launch with a dependent D instruction held.
    applyStimulus(1, 0, 1, 1, 2'b01, 0, 0);
    repeat (6) applyStimulus(1, 0, 1, 0, 2'b00, 0, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 0, 0);

    // Div launch killed by a same-cycle exception.
    applyStimulus(1, 0, 0, 1, 2'b10, 1, 0);
    repeat (2) applyStimulus(1, 0, 1, 0, 2'b00, 0, 0);

    // Hazard under bus_wait, then hazard alone.
    repeat (2) applyStimulus(1, 1, 0, 0, 2'b00, 0, 1);
    applyStimulus(1, 1, 0, 0, 2'b00, 0, 0);

    // Div freezing: bus_wait at count 4 for 3 cycles.
    applyStimulus(1, 0, 0, 1, 2'b10, 0, 0);
    repeat (6) applyStimulus(1, 0, 0, 0, 2'b00, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0, 2'b00, 0, 1);
    repeat (3) applyStimulus(1, 0, 1, 0, 2'b00, 0, 0);

    // Reset asserted mid-divide at count 7, then dependent use after release.
    applyStimulus(1, 0, 0, 1, 2'b10, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0, 2'b00, 0, 0);
    repeat (2) applyStimulus(0, 0, 1, 0, 2'b00, 0, 0);
    repeat (2) applyStimulus(1, 0, 1, 0, 2'b00, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(logic'($urandom_range(0, 63) != 0),
                    logic'($urandom_range(0, 3) == 0),
                    logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 3) == 0),
                    2'($urandom_range(0, 3)),
                    logic'($urandom_range(0, 7) == 0),
                    logic'($urandom_range(0, 5) == 0));
    end

    drained = 0;
    for (int k = 0; k < 5 && !drained; k++) begin
      @(negedge clk);
      #1;
      if (expQ.size() == 0) drained = 1;
    end
    checks++;
    if (!drained) begin
      failures++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
